// File: rtl/cnn_acc_pkg.sv
// Shared constants and types for the CNN accelerator feature-map buffers.
package cnn_acc_pkg;

    localparam int FMAP_DATA_W = 64;
    localparam int FMAP_ADDR_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        SWAP
    } fmap_state_t;

endpackage

// File: rtl/dp_bram_bank.sv
// Simple dual-port RAM bank: one write port, one registered read port.
// RD_LAT=2 adds an output register stage behind the array read.
module dp_bram_bank #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] q1;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) q1 <= mem[rd_addr];
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] q2;
        always_ff @(posedge clk) q2 <= q1;
        assign rd_data = q2;
    end else begin : g_lat1
        assign rd_data = q1;
    end

endmodule

// File: rtl/fmap_pingpong_buf.sv
// Ping-pong feature-map buffer: the producer fills one bank while the
// consumer randomly reads the other; banks swap once both sides are done.
module fmap_pingpong_buf
    import cnn_acc_pkg::*;
#(
    parameter int DATA_W = FMAP_DATA_W,
    parameter int ADDR_W = FMAP_ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              layer_start,
    input  logic [ADDR_W:0]   layer_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_done,
    output logic              wr_bank,
    output logic              busy,
    output logic              layer_done,
    output logic              cmd_err
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    fmap_state_t       state;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   wr_cnt;
    logic              rd_done_lat;
    logic [RD_LAT-1:0] rd_vld;
    logic [RD_LAT-1:0] rd_sel;
    logic              wr_fire;
    logic              rd_fire;
    logic              len_ok;
    logic [DATA_W-1:0] q0;
    logic [DATA_W-1:0] q1;

    assign wr_ready      = (state == RUN) && (wr_cnt < len);
    assign rd_req_ready  = (state == RUN) || (state == DRAIN);
    assign busy          = (state != IDLE);
    assign wr_fire       = wr_valid && wr_ready;
    assign rd_fire       = rd_req_valid && rd_req_ready;
    assign len_ok        = (layer_len != '0) && (layer_len <= MAX_LEN);
    assign rd_data_valid = rd_vld[RD_LAT-1];
    assign rd_data       = !rd_data_valid ? '0 : (rd_sel[RD_LAT-1] ? q1 : q0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_bank     <= 1'b0;
            wr_cnt      <= '0;
            len         <= '0;
            rd_done_lat <= 1'b0;
            layer_done  <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            layer_done <= 1'b0;
            cmd_err    <= 1'b0;
            if (layer_start && ((state != IDLE) || !len_ok)) cmd_err <= 1'b1;
            if (wr_fire) wr_cnt <= wr_cnt + (ADDR_W+1)'(1);
            // rd_done may arrive early in RUN; remember it until the swap
            if (rd_done && rd_req_ready) rd_done_lat <= 1'b1;
            case (state)
                IDLE: begin
                    if (layer_start && len_ok) begin
                        len         <= layer_len;
                        wr_cnt      <= '0;
                        rd_done_lat <= 1'b0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (wr_fire && ((wr_cnt + (ADDR_W+1)'(1)) == len)) state <= DRAIN;
                end
                DRAIN: begin
                    if (rd_done_lat && !rd_fire && (rd_vld == '0)) state <= SWAP;
                end
                SWAP: begin
                    wr_bank    <= ~wr_bank;
                    layer_done <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Valid and source bank travel with each read so a swap cannot misroute data
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld <= '0;
            rd_sel <= '0;
        end else begin
            rd_vld[0] <= rd_fire;
            rd_sel[0] <= ~wr_bank;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld[i] <= rd_vld[i-1];
                rd_sel[i] <= rd_sel[i-1];
            end
        end
    end

    dp_bram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_bank0 (
        .clk     (clk),
        .wr_en   (wr_fire && !wr_bank),
        .wr_addr (wr_cnt[ADDR_W-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_fire),
        .rd_addr (rd_addr),
        .rd_data (q0)
    );

    dp_bram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_bank1 (
        .clk     (clk),
        .wr_en   (wr_fire && wr_bank),
        .wr_addr (wr_cnt[ADDR_W-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_fire),
        .rd_addr (rd_addr),
        .rd_data (q1)
    );

endmodule

// File: tb/tb_fmap_pingpong_buf.sv
// Bench for fmap_pingpong_buf: reads are scoreboarded against a two-bank
// model fed by the accepted writes; layer sequencing is checked inline.
module tb_fmap_pingpong_buf;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 12;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct {
        logic [63:0] data;
        bit          chk;
        int          due;
    } rd_exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              layer_start;
    logic [ADDR_W:0]   layer_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_data_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_done;
    logic              wr_bank;
    logic              busy;
    logic              layer_done;
    logic              cmd_err;

    rd_exp_t     sb[$];
    logic [63:0] mdl   [2][DEPTH];
    bit          known [2][DEPTH];
    int          mdl_wcnt = 0;
    bit          exp_bank = 1'b0;
    int          edge_no  = 0;
    int          wr_acc   = 0;
    int          vld_seen = 0;
    int          errors   = 0;
    int          checks   = 0;

    always #5 clk = ~clk;

    fmap_pingpong_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .layer_start   (layer_start),
        .layer_len     (layer_len),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_addr       (rd_addr),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .rd_done       (rd_done),
        .wr_bank       (wr_bank),
        .busy          (busy),
        .layer_done    (layer_done),
        .cmd_err       (cmd_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Handshakes at each edge feed the model banks and the read scoreboard
    always @(posedge clk) begin
        edge_no++;
        if (rst) begin
            sb.delete();
        end else begin
            if (rd_req_valid && rd_req_ready) begin
                sb.push_back('{mdl[!exp_bank][rd_addr], known[!exp_bank][rd_addr],
                               edge_no + RD_LAT - 1});
            end
            if (wr_valid && wr_ready) begin
                mdl[exp_bank][mdl_wcnt % DEPTH]   = wr_data;
                known[exp_bank][mdl_wcnt % DEPTH] = 1'b1;
                mdl_wcnt++;
                wr_acc++;
            end
        end
    end

    always @(negedge clk) begin
        if (rd_data_valid === 1'b1) begin
            rd_exp_t e;
            vld_seen++;
            if (sb.size() == 0) begin
                checkOutput("spurious_rd_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("rd_latency", edge_no, e.due);
                if (e.chk) checkOutput("rd_data", rd_data, e.data);
            end
        end
    end

    initial begin
        #500us;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startLayer(input int n);
        layer_start = 1'b1;
        layer_len   = (ADDR_W+1)'(n);
        mdl_wcnt    = 0;
        tick();
        layer_start = 1'b0;
    endtask

    task automatic applyStimulus(input int count, input logic [63:0] base, input int gap);
        for (int i = 0; i < count; i++) begin
            int g;
            g        = 0;
            wr_valid = 1'b1;
            wr_data  = base + 64'(i);
            while (!wr_ready && g < 50) begin
                tick();
                g++;
            end
            if (g == 50) checkOutput("wr_ready_timeout", 0, 1);
            tick();
            wr_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic readAddr(input int a);
        rd_req_valid = 1'b1;
        rd_addr      = ADDR_W'(a);
        tick();
        rd_req_valid = 1'b0;
    endtask

    task automatic waitDone(input int exp_n);
        int n;
        n = 0;
        while (!layer_done && n < 20) begin
            tick();
            n++;
        end
        checkOutput("layer_done_latency", n, exp_n);
        checkOutput("wr_bank_swap", wr_bank, !exp_bank);
        exp_bank = !exp_bank;
    endtask

    task automatic finishLayer(input int idle);
        repeat (idle) tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        waitDone(2);
    endtask

    initial begin
        int addrs[4];
        int v0;
        addrs        = '{2, 0, 3, 1};
        rst          = 1'b1;
        layer_start  = 1'b0;
        layer_len    = '0;
        wr_valid     = 1'b0;
        wr_data      = '0;
        rd_req_valid = 1'b0;
        rd_addr      = '0;
        rd_done      = 1'b0;
        tick();
        tick();
        checkOutput("rst_wr_ready", wr_ready, 0);
        checkOutput("rst_rd_req_ready", rd_req_ready, 0);
        checkOutput("rst_rd_data_valid", rd_data_valid, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_layer_done", layer_done, 0);
        checkOutput("rst_cmd_err", cmd_err, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_wr_bank", wr_bank, 0);
        rst = 1'b0;
        tick();

        // Layer 1: B0 gets A0..A3; a read of the undefined B1 is timing-checked only
        startLayer(4);
        checkOutput("run_busy", busy, 1);
        checkOutput("run_wr_ready", wr_ready, 1);
        checkOutput("run_rd_req_ready", rd_req_ready, 1);
        readAddr(5);
        applyStimulus(4, 64'hA0, 0);
        checkOutput("drain_wr_ready", wr_ready, 0);
        checkOutput("drain_busy", busy, 1);
        checkOutput("drain_rd_req_ready", rd_req_ready, 1);
        tick();
        checkOutput("no_swap_before_rd_done", layer_done, 0);
        finishLayer(2);

        // Layer 2 starts right after the swap; reads of B0 overlap writes to B1
        startLayer(4);
        checkOutput("layer_done_one_cycle", layer_done, 0);
        checkOutput("restart_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            wr_valid     = 1'b1;
            wr_data      = 64'hB0 + 64'(i);
            rd_req_valid = 1'b1;
            rd_addr      = ADDR_W'(addrs[i]);
            checkOutput("wr_ready_concurrent", wr_ready, 1);
            tick();
        end
        wr_valid     = 1'b0;
        rd_req_valid = 1'b0;
        finishLayer(4);

        // Layer 3: rd_done arrives after the first write and is held until the last
        startLayer(4);
        applyStimulus(1, 64'hC0, 0);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        readAddr(1);
        repeat (3) tick();
        applyStimulus(2, 64'hC1, 1);
        checkOutput("early_rd_done_no_swap", layer_done, 0);
        checkOutput("early_rd_done_busy", busy, 1);
        applyStimulus(1, 64'hC3, 0);
        waitDone(2);

        // Illegal commands
        tick();
        layer_start = 1'b1;
        layer_len   = '0;
        tick();
        layer_start = 1'b0;
        checkOutput("cmd_err_len0", cmd_err, 1);
        checkOutput("len0_busy", busy, 0);
        tick();
        checkOutput("cmd_err_pulse", cmd_err, 0);
        layer_start = 1'b1;
        layer_len   = (ADDR_W+1)'(DEPTH + 1);
        tick();
        layer_start = 1'b0;
        checkOutput("cmd_err_len_big", cmd_err, 1);
        checkOutput("len_big_busy", busy, 0);
        startLayer(2);
        layer_start = 1'b1;
        layer_len   = (ADDR_W+1)'(3);
        tick();
        layer_start = 1'b0;
        checkOutput("cmd_err_in_run", cmd_err, 1);
        checkOutput("run_kept_busy", busy, 1);
        applyStimulus(2, 64'hE0, 0);
        checkOutput("len_unchanged", wr_ready, 0);
        finishLayer(2);

        // Full bank: hold wr_valid well past the length
        startLayer(DEPTH);
        wr_acc = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 64'hF00D_0000_0000_0000 | 64'(i);
            tick();
        end
        wr_valid = 1'b0;
        checkOutput("full_write_count", wr_acc, DEPTH);
        checkOutput("full_wr_ready", wr_ready, 0);
        finishLayer(2);

        // Read the full bank's ends, then reset with a read in flight
        startLayer(1);
        readAddr(0);
        readAddr(DEPTH - 1);
        readAddr(DEPTH / 2);
        applyStimulus(1, 64'hD0, 0);
        repeat (3) tick();
        readAddr(3);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        exp_bank = 1'b0;
        v0       = vld_seen;
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("post_rst_wr_bank", wr_bank, 0);
        checkOutput("post_rst_rd_req_ready", rd_req_ready, 0);
        checkOutput("post_rst_rd_data_valid", rd_data_valid, 0);
        repeat (5) tick();
        checkOutput("no_valid_after_rst", vld_seen - v0, 0);
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fmap_pingpong_buf.md
FMAP_PINGPONG_BUF -- requirements
Module: fmap_pingpong_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 64, word width of feature-map data.
REQ-002 SHALL have parameter ADDR_W, default 12, bank address width; each bank holds 2^ADDR_W words.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values are 1 or 2.
REQ-004 SHALL have port clk  in  1  the single clock for all logic.
REQ-005 SHALL have port rst  in  1  reset, synchronous to clk and active-high.
REQ-006 SHALL have port layer_start  in  1  one-cycle pulse that starts a layer.
REQ-007 SHALL have port layer_len  in  ADDR_W+1  number of words the layer writes, sampled on layer_start.
REQ-008 SHALL have ports wr_valid (in, 1), wr_ready (out, 1) and wr_data (in, DATA_W) forming the producer (PE output) write stream.
REQ-009 SHALL have ports rd_req_valid (in, 1), rd_req_ready (out, 1) and rd_addr (in, ADDR_W) forming the consumer random-read request.
REQ-010 SHALL have ports rd_data_valid (out, 1) and rd_data (out, DATA_W) carrying the read response.
REQ-011 SHALL have port rd_done  in  1  pulse from the consumer meaning it has finished reading the previous layer.
REQ-012 SHALL have status outputs wr_bank (1), busy (1), layer_done (1, pulse) and cmd_err (1, pulse).

Function
REQ-013 SHALL contain two banks, B0 and B1; writes go to bank wr_bank and reads are served from bank ~wr_bank.
REQ-014 SHALL implement the states IDLE, RUN, DRAIN and SWAP; busy SHALL be high in every state except IDLE.
REQ-015 SHALL, in IDLE on layer_start with layer_len in 1..2^ADDR_W: latch len, clear wr_cnt and the rd_done latch, and go to RUN.
REQ-016 SHALL, in IDLE on layer_start with layer_len=0 or layer_len>2^ADDR_W: stay in IDLE and pulse cmd_err for 1 cycle.
REQ-017 SHALL ignore layer_start in any state other than IDLE and pulse cmd_err for 1 cycle.
REQ-018 SHALL drive wr_ready=1 only in RUN with wr_cnt<len.
REQ-019 SHALL, on wr_valid&&wr_ready, write wr_data to bank[wr_bank][wr_cnt] and increment wr_cnt.
REQ-020 SHALL go from RUN to DRAIN in the cycle after the write that makes wr_cnt==len.
REQ-021 SHALL drive rd_req_ready=1 in RUN and DRAIN and 0 in IDLE and SWAP.
REQ-022 SHALL, for each request accepted in cycle t, present rd_data=bank[~wr_bank][rd_addr] with rd_data_valid=1 in cycle t+RD_LAT.
REQ-023 SHALL sustain one read per cycle, and reads and writes SHALL proceed concurrently without conflict because they target different banks.
REQ-024 SHALL latch rd_done whenever it arrives in RUN or DRAIN, including before all writes complete.
REQ-025 SHALL go from DRAIN to SWAP when the rd_done latch is set and no read is in flight.
REQ-026 SHALL, in SWAP (one cycle): toggle wr_bank, pulse layer_done for 1 cycle, and return to IDLE.
REQ-027 SHALL leave rd_data and rd_data_valid functionally correct for reads issued on the first layer after reset, even though the read bank then holds undefined content; the consumer pulses rd_done immediately on that layer.
REQ-028 SHALL permit a layer_start issued in the cycle after SWAP to be accepted.

Reset
REQ-029 SHALL, while rst=1 on a clk edge, force state=IDLE, wr_bank=0 and wr_cnt=0, and clear the rd_done latch.
REQ-030 SHALL, during reset, drive wr_ready, rd_req_ready, rd_data_valid, layer_done, cmd_err and busy to 0 and rd_data to all-zero.
REQ-031 SHALL, on reset mid-operation, discard any in-flight read so that no rd_data_valid appears after reset; bank contents are not cleared.

Structure
REQ-032 SHALL take the default DATA_W/ADDR_W constants and the state enum type from shared package cnn_acc_pkg.
REQ-033 SHALL instantiate sub-module dp_bram_bank twice; each instance is an inferred simple dual-port RAM with one write port, one read port and read latency RD_LAT.

Verification
REQ-034 Basic layer: layer_start with len=4, write 0xA0..0xA3, then rd_done -> layer_done 1 cycle after DRAIN exit, and wr_bank goes 0->1.
REQ-035 Readback: in the second layer, request rd_addr=2 with RD_LAT=2 -> rd_data=0xA2 with rd_data_valid exactly 2 cycles after acceptance, while concurrent writes land in B1.
REQ-036 Early rd_done: rd_done pulsed in RUN at wr_cnt=1 of len=4 -> no swap until the 4th write, then SWAP follows without a second rd_done.
REQ-037 Errors: layer_start with len=0 -> cmd_err pulse, busy stays 0; layer_start while in RUN -> cmd_err pulse and len unchanged.
REQ-038 Full bank: len=4096 -> exactly 4096 writes accepted, wr_ready=0 after the last one, and the address wraps no earlier.
REQ-039 Reset mid-operation: assert rst 1 cycle after a read request -> no rd_data_valid, wr_bank=0, and state IDLE next cycle.
